// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, imem request port, IF/ID register and skid buffer
//
// Purpose:
//   Owns the program counter and issues one instruction-memory transaction
//   at a time on a req/ready port. Completed fetches are written into the
//   IF/ID pipeline register that feeds decode. A decode stall that coincides
//   with a completing fetch parks the instruction in a one-entry skid buffer
//   (HOLD state). An execute redirect flushes IF/ID and steers the PC. If a
//   transaction is still in flight, its response is dropped when it arrives.
//
// Ports:
//   clk              in   single clock, rising-edge updates
//   rst              in   synchronous active-low reset
//   hazard_detected  in   decode stall request; IF/ID and PC hold
//   branch_taken     in   execute redirect/flush pulse
//   branch_addr      in   redirect target, valid with branch_taken
//   imem_req         out  fetch request
//   imem_addr        out  fetch address, held stable until imem_ready
//   imem_ready       in   transaction complete, imem_rdata valid
//   imem_rdata       in   fetched instruction
//   instr_ID         out  IF/ID instruction
//   pc_ID            out  address of instr_ID
//   valid_ID         out  IF/ID holds a real instruction (0 = bubble)

module fetch_stage #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter int                 PC_STEP  = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard_detected,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_ID,
  output logic [ADDR_W-1:0]  pc_ID,
  output logic               valid_ID
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;         // next address to fetch
  logic [ADDR_W-1:0]   r_req_addr;   // address presented on imem_addr
  logic                r_req;
  logic                r_drop;       // response of the in-flight fetch is stale
  logic                r_skid_valid;
  logic [INSTR_W-1:0]  r_skid_instr;
  logic [ADDR_W-1:0]   r_skid_pc;
  logic [INSTR_W-1:0]  r_instr_id;
  logic [ADDR_W-1:0]   r_pc_id;
  logic                r_valid_id;

  logic [ADDR_W-1:0]   w_next_seq;
  logic [ADDR_W-1:0]   w_restart;

  // Sequential successor of the address being fetched; wraps silently.
  assign w_next_seq = r_req_addr + STEP;

  // Where to restart after a discarded response: a same-cycle redirect wins
  // over the target remembered from an earlier redirect.
  assign w_restart  = branch_taken ? branch_addr : r_pc;

  assign imem_req   = r_req;
  assign imem_addr  = r_req_addr;
  assign instr_ID   = r_instr_id;
  assign pc_ID      = r_pc_id;
  assign valid_ID   = r_valid_id;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_req        <= 1'b0;
      r_drop       <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_instr_id   <= '0;
      r_pc_id      <= '0;
      r_valid_id   <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            // First cycle out of reset: nothing outstanding, start fetching.
            r_req <= 1'b1;
            if (branch_taken) begin
              r_pc       <= branch_addr;
              r_req_addr <= branch_addr;
              r_valid_id <= 1'b0;
            end else begin
              r_req_addr <= r_pc;
            end
          end else if (imem_ready) begin
            if (r_drop || branch_taken) begin
              // Stale or flushed response: discard and restart at the target.
              r_drop     <= 1'b0;
              r_pc       <= w_restart;
              r_req_addr <= w_restart;
              r_valid_id <= 1'b0;
            end else if (!hazard_detected) begin
              r_instr_id <= imem_rdata;
              r_pc_id    <= r_req_addr;
              r_valid_id <= 1'b1;
              r_pc       <= w_next_seq;
              r_req_addr <= w_next_seq;
            end else begin
              // Decode is stalled: park the instruction and stop requesting.
              r_skid_instr <= imem_rdata;
              r_skid_pc    <= r_req_addr;
              r_skid_valid <= 1'b1;
              r_pc         <= w_next_seq;
              r_req_addr   <= w_next_seq;
              r_req        <= 1'b0;
              r_state      <= S_HOLD;
            end
          end else if (branch_taken) begin
            // Address must stay stable until ready; remember to drop the data.
            r_pc       <= branch_addr;
            r_drop     <= 1'b1;
            r_valid_id <= 1'b0;
          end else if (!hazard_detected) begin
            r_valid_id <= 1'b0;
          end
        end

        S_HOLD: begin
          if (branch_taken) begin
            r_skid_valid <= 1'b0;
            r_pc         <= branch_addr;
            r_req_addr   <= branch_addr;
            r_valid_id   <= 1'b0;
            r_req        <= 1'b1;
            r_state      <= S_FETCH;
          end else if (!hazard_detected) begin
            // Skid drains into ID while the next fetch is issued this cycle.
            r_instr_id   <= r_skid_instr;
            r_pc_id      <= r_skid_pc;
            r_valid_id   <= r_skid_valid;
            r_skid_valid <= 1'b0;
            r_req_addr   <= r_pc;
            r_req        <= 1'b1;
            r_state      <= S_FETCH;
          end
        end

        default: begin
          r_state <= S_FETCH;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage

module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        hazard_detected;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_ID;
  logic [31:0] pc_ID;
  logic        valid_ID;

  int n_pass;
  int n_total;

  fetch_stage #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .PC_STEP (4),
    .RESET_PC(32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hazard_detected(hazard_detected),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instr_ID       (instr_ID),
    .pc_ID          (pc_ID),
    .valid_ID       (valid_ID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; hazard_detected = 1'b0; branch_taken = 1'b0;
    branch_addr = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; hazard_detected = 1'b0; branch_taken = 1'b0;
    branch_addr = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
    step(); step(); step();
    n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%0b exp=0", imem_req); else n_pass++;
    n_total++; if (valid_ID !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", valid_ID); else n_pass++;
    n_total++; if (pc_ID !== 32'h0) $display("FAIL reset_pc_id got=%h exp=0", pc_ID); else n_pass++;
    n_total++; if (instr_ID !== 32'h0) $display("FAIL reset_instr_id got=%h exp=0", instr_ID); else n_pass++;
    rst = 1'b1;
    step();
    n_total++; if (imem_req !== 1'b1) $display("FAIL release_req got=%0b exp=1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL release_addr got=%h exp=0", imem_addr); else n_pass++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_a;
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_a = 32'(i * 4);
      imem_rdata = imem_addr;
      step();
      n_total++; if (instr_ID !== exp_a) $display("FAIL stream_instr[%0d] got=%h exp=%h", i, instr_ID, exp_a); else n_pass++;
      n_total++; if (pc_ID !== exp_a) $display("FAIL stream_pc[%0d] got=%h exp=%h", i, pc_ID, exp_a); else n_pass++;
      n_total++; if (valid_ID !== 1'b1) $display("FAIL stream_valid[%0d] got=%0b exp=1", i, valid_ID); else n_pass++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = imem_addr;
      step();
    end
    n_total++; if (instr_ID !== 32'h8) $display("FAIL stall_pre_id got=%h exp=8", instr_ID); else n_pass++;
    hazard_detected = 1'b1; imem_rdata = 32'hC;
    step();
    n_total++; if (instr_ID !== 32'h8) $display("FAIL stall_hold1_id got=%h exp=8", instr_ID); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL stall_hold1_req got=%0b exp=0", imem_req); else n_pass++;
    imem_ready = 1'b0;
    step();
    n_total++; if (instr_ID !== 32'h8) $display("FAIL stall_hold2_id got=%h exp=8", instr_ID); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL stall_hold2_req got=%0b exp=0", imem_req); else n_pass++;
    hazard_detected = 1'b0;
    step();
    n_total++; if (instr_ID !== 32'hC || pc_ID !== 32'hC || valid_ID !== 1'b1)
      $display("FAIL stall_skid_out got=%h/%h/%0b exp=c/c/1", instr_ID, pc_ID, valid_ID); else n_pass++;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10)
      $display("FAIL stall_refetch got=%0b/%h exp=1/10", imem_req, imem_addr); else n_pass++;
    imem_ready = 1'b1; imem_rdata = 32'h10;
    step();
    n_total++; if (instr_ID !== 32'h10 || valid_ID !== 1'b1)
      $display("FAIL stall_no_gap got=%h/%0b exp=10/1", instr_ID, valid_ID); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata = imem_addr;
      step();
    end
    n_total++; if (imem_addr !== 32'h10) $display("FAIL redir_pre_addr got=%h exp=10", imem_addr); else n_pass++;
    imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h40;
    step();
    branch_taken = 1'b0; branch_addr = 32'h0;
    n_total++; if (imem_addr !== 32'h10 || imem_req !== 1'b1)
      $display("FAIL redir_wait1 got=%0b/%h exp=1/10", imem_req, imem_addr); else n_pass++;
    n_total++; if (valid_ID !== 1'b0) $display("FAIL redir_flush_valid got=%0b exp=0", valid_ID); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++; if (imem_addr !== 32'h10 || valid_ID !== 1'b0)
        $display("FAIL redir_wait_hold[%0d] got=%h/%0b exp=10/0", i, imem_addr, valid_ID); else n_pass++;
    end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD0010;
    step();
    n_total++; if (imem_addr !== 32'h40 || valid_ID !== 1'b0)
      $display("FAIL redir_dropped got=%h/%0b exp=40/0", imem_addr, valid_ID); else n_pass++;
    imem_rdata = 32'h40;
    step();
    n_total++; if (instr_ID !== 32'h40 || pc_ID !== 32'h40 || valid_ID !== 1'b1)
      $display("FAIL redir_target got=%h/%h/%0b exp=40/40/1", instr_ID, pc_ID, valid_ID); else n_pass++;
  endtask

  task automatic test_flush_beats_stall();
    do_reset();
    imem_ready = 1'b1; imem_rdata = 32'h0;
    step();
    hazard_detected = 1'b1; imem_rdata = 32'h4;
    step();
    n_total++; if (imem_req !== 1'b0) $display("FAIL fbs_in_hold got=%0b exp=0", imem_req); else n_pass++;
    imem_ready = 1'b0; branch_taken = 1'b1; branch_addr = 32'h80;
    step();
    branch_taken = 1'b0; hazard_detected = 1'b0;
    n_total++; if (valid_ID !== 1'b0) $display("FAIL fbs_valid got=%0b exp=0", valid_ID); else n_pass++;
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h80)
      $display("FAIL fbs_addr got=%0b/%h exp=1/80", imem_req, imem_addr); else n_pass++;
    imem_ready = 1'b1; imem_rdata = 32'h80;
    step();
    n_total++; if (pc_ID !== 32'h80 || valid_ID !== 1'b1)
      $display("FAIL fbs_skid_cleared got=%h/%0b exp=80/1", pc_ID, valid_ID); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ready = 1'b1; imem_rdata = 32'h0; branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    n_total++; if (imem_addr !== 32'hFFFF_FFFC || valid_ID !== 1'b0)
      $display("FAIL wrap_redirect got=%h/%0b exp=fffffffc/0", imem_addr, valid_ID); else n_pass++;
    imem_rdata = 32'h1234_5678;
    step();
    n_total++; if (pc_ID !== 32'hFFFF_FFFC || instr_ID !== 32'h1234_5678)
      $display("FAIL wrap_id got=%h/%h exp=fffffffc/12345678", pc_ID, instr_ID); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL wrap_next got=%h exp=0", imem_addr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      imem_rdata = imem_addr;
      step();
    end
    imem_ready = 1'b0;
    step();
    n_total++; if (imem_addr !== 32'h20 || imem_req !== 1'b1)
      $display("FAIL rmid_waiting got=%0b/%h exp=1/20", imem_req, imem_addr); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if (imem_req !== 1'b0 || valid_ID !== 1'b0)
      $display("FAIL rmid_reset got=%0b/%0b exp=0/0", imem_req, valid_ID); else n_pass++;
    rst = 1'b1;
    step();
    n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL rmid_restart got=%0b/%h exp=1/0", imem_req, imem_addr); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_wait();
    test_flush_beats_stall();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 5-stage pipeline. It owns the PC, drives a req/ready instruction-memory port, and writes the IF/ID pipeline register that feeds decode. It consumes `hazard_detected` from decode's hazard unit to stall, and `branch_taken`/`branch_addr` from execute to flush and redirect. A one-entry skid buffer absorbs a fetch that completes while decode is stalled.

## Interface
Parameters:
- `ADDR_W`, 32, PC and memory address width
- `INSTR_W`, 32, instruction width
- `PC_STEP`, 4, PC increment per instruction
- `RESET_PC`, 0, first fetch address after reset

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge)
- `hazard_detected`  in  1  decode stall request; IF/ID and PC must hold
- `branch_taken`  in  1  execute redirect/flush, one-cycle pulse
- `branch_addr`  in  ADDR_W  redirect target, valid with `branch_taken`
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_W  fetch address, stable while `imem_req`=1 and `imem_ready`=0
- `imem_ready`  in  1  transaction complete, `imem_rdata` valid this cycle
- `imem_rdata`  in  INSTR_W  fetched instruction
- `instr_ID`  out  INSTR_W  IF/ID instruction
- `pc_ID`  out  ADDR_W  address of `instr_ID`
- `valid_ID`  out  1  IF/ID holds a real instruction; 0 = bubble

## Operation
- State: `pc` (next address to fetch), `req_addr` (address of the outstanding transaction), `drop` flag, skid buffer (`skid_instr`, `skid_pc`), FSM {FETCH, HOLD}.
- Reset (`rst`=0): `pc`=RESET_PC, FSM=FETCH, `drop`=0, skid empty, `imem_req`=0, `valid_ID`=0, `instr_ID`=0, `pc_ID`=0. A transaction in flight when reset asserts is abandoned; memory must tolerate this.
- FETCH: `imem_req`=1, `imem_addr`=`req_addr`. `req_addr` loads `pc` only when no transaction is outstanding.
  - `imem_ready`=1, `drop`=1: discard data, clear `drop`, issue at `pc`.
  - `imem_ready`=1, `branch_taken`=1: discard, `pc`<=`branch_addr`, `valid_ID`<=0.
  - `imem_ready`=1, `hazard_detected`=0: IF/ID <= {rdata, req_addr, 1}, `pc`<=`req_addr`+PC_STEP.
  - `imem_ready`=1, `hazard_detected`=1: skid <= {rdata, req_addr}, `pc`<=`req_addr`+PC_STEP, go to HOLD.
  - `imem_ready`=0, `branch_taken`=1: `pc`<=`branch_addr`, `drop`<=1, `valid_ID`<=0; the request stays stable until ready.
  - `imem_ready`=0, no branch: `valid_ID`<=0 unless `hazard_detected`, which holds IF/ID.
- HOLD: `imem_req`=0. IF/ID holds.
  - `branch_taken`=1: clear skid, `pc`<=`branch_addr`, `valid_ID`<=0, go to FETCH.
  - `hazard_detected`=0: IF/ID <= {skid, 1}, go to FETCH.
- Priority: reset > `branch_taken` > `hazard_detected`. A flush always overrides a stall, including the `valid_ID` clear.
- PC arithmetic is modulo 2^ADDR_W; wrap is silent.

## Timing
- Latency: `imem_ready` in cycle N puts the instruction in IF/ID at N+1.
- With zero-wait memory (`imem_ready`=1 in every request cycle) throughput is one instruction per cycle.
- First `imem_req`=1 occurs in the first cycle after `rst` deasserts.
- Stall exit from HOLD: the skid instruction reaches ID one cycle after `hazard_detected` falls. The next fetch is issued in that same cycle, so there is no bubble with zero-wait memory.
- Flush: `branch_taken` in cycle N gives `valid_ID`=0 at N+1. The first request to `branch_addr` is at N+1 if nothing is outstanding, otherwise in the cycle after the dropped transaction completes.
- `imem_addr` must never change while `imem_req`=1 and `imem_ready`=0.

## Test plan
- Reset: hold `rst`=0 for 3 cycles → `imem_req`=0, `valid_ID`=0, `pc_ID`=0. Release → `imem_req`=1, `imem_addr`=0x0 in the next cycle.
- Zero-wait stream: `imem_ready`=1, `imem_rdata`=address → `instr_ID`/`pc_ID` = 0x0, 0x4, 0x8, 0xC on consecutive cycles, `valid_ID`=1.
- Stall: `hazard_detected`=1 for 2 cycles while 0x8 is in ID → `instr_ID` holds 0x8, skid holds 0xC, `imem_req`=0 in HOLD. After release, ID shows 0xC then 0x10 with no gap.
- Redirect during wait: `imem_ready`=0 for 3 cycles at address 0x10, `branch_taken`=1 with `branch_addr`=0x40 in the first cycle → `imem_addr` stays 0x10 until ready, the response is dropped, the next request is 0x40, `valid_ID`=0 until 0x40 arrives.
- Flush beats stall: `branch_taken`=1 and `hazard_detected`=1 in the same cycle while in HOLD → skid cleared, `valid_ID`=0, next `imem_addr`=`branch_addr`.
- Reset mid-transaction: `rst`=0 while waiting on 0x20 → next cycle `imem_req`=0 and `valid_ID`=0. After release, the first fetch is RESET_PC.
